// File: rtl/pipe_ctrl_n_pkg.sv
// Shared constants for the pipeline hazard controller: exception codes,
// FSM state encodings and the common stop/reset levels.
package pipe_ctrl_n_pkg;

   // Exception code that returns from an exception handler via EPC
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   // FSM state encodings, kept as plain constants for older tooling
   localparam logic [0:0] PCTRL_RUN   = 1'b0;
   localparam logic [0:0] PCTRL_DRAIN = 1'b1;

   // Level that freezes a stage and level that asserts reset
   localparam logic STOP       = 1'b1;
   localparam logic RST_ENABLE = 1'b1;

   // True when the exception code requests a return to EPC
   function automatic logic is_eret(input logic [31:0] code);
      return code == EXC_ERET;
   endfunction

endpackage

// File: rtl/pipe_ctrl_n_stall_decode.sv
// Priority stall decode: the highest requesting stage and every stage in
// front of it are frozen, so younger instructions never overrun an older one.
module stall_decode
   import pipe_ctrl_n_pkg::*;
#(
   parameter int NUM_STAGES = 6
) (
   input  logic [NUM_STAGES-1:0] stallreq,
   output logic [NUM_STAGES-1:0] stall
);

   // Bit 0 is the PC register, which never requests a stall itself
   logic unused_pc_req;
   assign unused_pc_req = stallreq[0];

   // A stage stalls when it or any later stage (index >= 1) requests a stall
   always_comb begin
      logic any_req;
      stall   = '0;
      any_req = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 1; i--) begin
         any_req  = any_req | stallreq[i];
         stall[i] = any_req ? STOP : 1'b0;
      end
      stall[0] = any_req ? STOP : 1'b0;
   end

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline hazard controller: merges per-stage stall requests into the
// stall vector, flushes and redirects on exceptions/ERET, masks exceptions
// for a few drain cycles after a flush, supports a debug freeze, and keeps
// a stall watchdog plus a saturating stall-cycle counter.
module pipe_ctrl_n
   import pipe_ctrl_n_pkg::*;
#(
   parameter int                NUM_STAGES    = 6,
   parameter int                ADDR_W        = 32,
   parameter logic [ADDR_W-1:0] EXC_VECTOR    = 32'h0000_0020,
   parameter int                DRAIN_CYCLES  = 2,
   parameter int                STALL_TIMEOUT = 64,
   parameter int                CNT_W         = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_STAGES-1:0] stallreq,
   input  logic                  dbg_halt,
   input  logic [31:0]           excepttype,
   input  logic [ADDR_W-1:0]     cp0_epc,
   output logic [NUM_STAGES-1:0] stall,
   output logic                  flush,
   output logic [ADDR_W-1:0]     new_pc,
   output logic                  stall_timeout,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam int SC_W    = $clog2(STALL_TIMEOUT + 1);

   logic [0:0]            state;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic [SC_W-1:0]       stall_cnt;
   logic [NUM_STAGES-1:0] req_vec;
   logic                  exc_take;
   logic                  req_stall;

   stall_decode #(
      .NUM_STAGES (NUM_STAGES)
   ) u_stall_decode (
      .stallreq (stallreq),
      .stall    (req_vec)
   );

   assign exc_take = (rst != RST_ENABLE) && (state == PCTRL_RUN) && (excepttype != 32'h0);

   // Output priority: reset, then exception flush, then debug freeze, then requests
   always_comb begin
      stall  = '0;
      flush  = 1'b0;
      new_pc = '0;
      if (rst == RST_ENABLE) begin
         stall = '0;
      end else if (exc_take) begin
         flush  = 1'b1;
         new_pc = is_eret(excepttype) ? cp0_epc : EXC_VECTOR;
      end else if (dbg_halt) begin
         stall = {NUM_STAGES{STOP}};
      end else begin
         stall = req_vec;
      end
   end

   // Only stalls caused by stage requests count toward watchdog and perf counter
   assign req_stall = (stall != '0) && !dbg_halt && !flush;

   // Flush/drain FSM: after a flush, exceptions are dropped for DRAIN_CYCLES cycles
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state     <= PCTRL_RUN;
         drain_cnt <= '0;
      end else begin
         case (state)
            PCTRL_RUN: begin
               if (exc_take) begin
                  state     <= PCTRL_DRAIN;
                  drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
               end
            end
            default: begin
               if (drain_cnt == '0) begin
                  state <= PCTRL_RUN;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
         endcase
      end
   end

   // Watchdog: count consecutive request stalls and latch a sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         stall_cnt     <= '0;
         stall_timeout <= 1'b0;
      end else if (req_stall) begin
         if (stall_cnt != SC_W'(STALL_TIMEOUT)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (stall_cnt == SC_W'(STALL_TIMEOUT - 1)) begin
            stall_timeout <= 1'b1;
         end
      end else begin
         stall_cnt <= '0;
      end
   end

   // Performance counter of request-stall cycles, saturating at all ones
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         stall_cycles <= '0;
      end else if (req_stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed self-checking bench for pipe_ctrl_n with N=6 and default parameters.
module tb_pipe_ctrl_n;

   logic        clk;
   logic        rst;
   logic [5:0]  stallreq;
   logic        dbg_halt;
   logic [31:0] excepttype;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
   logic [31:0] stall_cycles;

   int total;
   int bad;

   pipe_ctrl_n dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq      (stallreq),
      .dbg_halt      (dbg_halt),
      .excepttype    (excepttype),
      .cp0_epc       (cp0_epc),
      .stall         (stall),
      .flush         (flush),
      .new_pc        (new_pc),
      .stall_timeout (stall_timeout),
      .stall_cycles  (stall_cycles)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports a mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives all inputs and lets combinational outputs settle
   task automatic applyStimulus(input logic r, input logic [5:0] req, input logic halt,
                                input logic [31:0] exc, input logic [31:0] epc);
      rst        = r;
      stallreq   = req;
      dbg_halt   = halt;
      excepttype = exc;
      cp0_epc    = epc;
      #1;
   endtask

   // Advances one clock edge and samples shortly after it
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // Reset: combinational outputs held at zero even with requests present
      applyStimulus(1'b1, 6'b001100, 1'b0, 32'h1, 32'h0);
      tick(2);
      checkOutput("rst_stall", stall, 6'b000000);
      checkOutput("rst_flush", flush, 1'b0);
      checkOutput("rst_newpc", new_pc, 32'h0);
      checkOutput("rst_timeout", stall_timeout, 1'b0);
      checkOutput("rst_cycles", stall_cycles, 32'd0);

      // Stall decode patterns
      applyStimulus(1'b0, 6'b001100, 1'b0, 32'h0, 32'h0);
      checkOutput("dec_id_ex", stall, 6'b001111);
      checkOutput("dec_flush0", flush, 1'b0);
      applyStimulus(1'b0, 6'b000100, 1'b0, 32'h0, 32'h0);
      checkOutput("dec_id", stall, 6'b000111);
      applyStimulus(1'b0, 6'b001000, 1'b0, 32'h0, 32'h0);
      checkOutput("dec_ex", stall, 6'b001111);
      applyStimulus(1'b0, 6'b000001, 1'b0, 32'h0, 32'h0);
      checkOutput("dec_bit0", stall, 6'b000000);
      applyStimulus(1'b0, 6'b100010, 1'b0, 32'h0, 32'h0);
      checkOutput("dec_wb", stall, 6'b111111);
      checkOutput("dec_newpc0", new_pc, 32'h0);

      // Perf counter: three request-stall cycles
      applyStimulus(1'b0, 6'b001100, 1'b0, 32'h0, 32'h0);
      tick(3);
      checkOutput("cycles_3", stall_cycles, 32'd3);

      // Exception with a pending stall request: flush wins, then drain window
      applyStimulus(1'b0, 6'b001000, 1'b0, 32'h1, 32'h0);
      checkOutput("exc_flush", flush, 1'b1);
      checkOutput("exc_stall", stall, 6'b000000);
      checkOutput("exc_newpc", new_pc, 32'h20);
      tick(1);
      checkOutput("drain1_flush", flush, 1'b0);
      checkOutput("drain1_stall", stall, 6'b001111);
      checkOutput("drain1_newpc", new_pc, 32'h0);
      checkOutput("exc_nocount", stall_cycles, 32'd3);
      tick(1);
      checkOutput("drain2_flush", flush, 1'b0);
      tick(1);
      checkOutput("reaccept_flush", flush, 1'b1);
      checkOutput("reaccept_newpc", new_pc, 32'h20);
      checkOutput("drain_counted", stall_cycles, 32'd5);
      tick(1);
      applyStimulus(1'b0, 6'b000000, 1'b0, 32'h0, 32'h0);
      tick(2);

      // ERET redirects to EPC
      applyStimulus(1'b0, 6'b000000, 1'b0, 32'h0000_000e, 32'h0000_1234);
      checkOutput("eret_flush", flush, 1'b1);
      checkOutput("eret_newpc", new_pc, 32'h0000_1234);
      tick(1);
      applyStimulus(1'b0, 6'b000000, 1'b0, 32'h0, 32'h0);
      tick(2);

      // Debug halt freezes everything without counting
      applyStimulus(1'b0, 6'b000000, 1'b1, 32'h0, 32'h0);
      checkOutput("halt_stall", stall, 6'b111111);
      checkOutput("halt_flush", flush, 1'b0);
      tick(2);
      checkOutput("halt_nocount", stall_cycles, 32'd5);
      applyStimulus(1'b0, 6'b000100, 1'b1, 32'h1, 32'h0);
      checkOutput("halt_exc_flush", flush, 1'b1);
      checkOutput("halt_exc_stall", stall, 6'b000000);
      checkOutput("halt_exc_newpc", new_pc, 32'h20);
      tick(1);
      applyStimulus(1'b0, 6'b000000, 1'b0, 32'h0, 32'h0);
      tick(2);
      checkOutput("halt_exc_nocount", stall_cycles, 32'd5);

      // Watchdog: 63 cycles no timeout, 64th edge sets it, sticky afterwards
      applyStimulus(1'b0, 6'b000100, 1'b0, 32'h0, 32'h0);
      tick(63);
      checkOutput("wd_63", stall_timeout, 1'b0);
      tick(1);
      checkOutput("wd_64", stall_timeout, 1'b1);
      applyStimulus(1'b0, 6'b000000, 1'b0, 32'h0, 32'h0);
      tick(2);
      checkOutput("wd_sticky", stall_timeout, 1'b1);
      checkOutput("wd_cycles", stall_cycles, 32'd69);

      // Reset clears the flag; 63 + gap + 63 never times out
      applyStimulus(1'b1, 6'b000000, 1'b0, 32'h0, 32'h0);
      tick(1);
      applyStimulus(1'b0, 6'b000100, 1'b0, 32'h0, 32'h0);
      checkOutput("wd_rst_flag", stall_timeout, 1'b0);
      tick(63);
      applyStimulus(1'b0, 6'b000000, 1'b0, 32'h0, 32'h0);
      tick(1);
      applyStimulus(1'b0, 6'b000100, 1'b0, 32'h0, 32'h0);
      tick(63);
      checkOutput("wd_gap", stall_timeout, 1'b0);
      checkOutput("wd_gap_cycles", stall_cycles, 32'd126);

      // Halt cycles restart the watchdog run
      applyStimulus(1'b0, 6'b000100, 1'b1, 32'h0, 32'h0);
      tick(1);
      applyStimulus(1'b0, 6'b000100, 1'b0, 32'h0, 32'h0);
      tick(2);
      checkOutput("wd_halt_restart", stall_timeout, 1'b0);

      // Reset in the middle of DRAIN with counters non-zero
      applyStimulus(1'b0, 6'b000100, 1'b0, 32'h1, 32'h0);
      tick(1);
      applyStimulus(1'b1, 6'b000100, 1'b0, 32'h1, 32'h0);
      checkOutput("mid_rst_stall", stall, 6'b000000);
      checkOutput("mid_rst_flush", flush, 1'b0);
      tick(1);
      checkOutput("mid_rst_cycles", stall_cycles, 32'd0);
      checkOutput("mid_rst_timeout", stall_timeout, 1'b0);
      applyStimulus(1'b0, 6'b000000, 1'b0, 32'h1, 32'h0);
      checkOutput("post_rst_flush", flush, 1'b1);
      checkOutput("post_rst_newpc", new_pc, 32'h20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
